// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file: read ports,
// writeback port, issue-claim handshake, flush, PC read-through and error flag.
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]    ra;
  logic [NRD*WIDTH-1:0] rd;
  logic [NRD-1:0]       rbusy;
  logic                 we;
  logic [AW-1:0]        wa;
  logic [WIDTH-1:0]     wd;
  logic                 iss_valid;
  logic [AW-1:0]        iss_addr;
  logic                 iss_ready;
  logic                 flush;
  logic [WIDTH-1:0]     pc_in;
  logic                 err;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_addr, flush, pc_in,
    input  rd, rbusy, iss_ready, err
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_addr, flush, pc_in,
    output rd, rbusy, iss_ready, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with NRD bypassed read ports, PC read-through on the top register
// and saturating per-register pending-write counters for RAW hazard detection.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int NRD    = 2,
  parameter int CNTW   = 2,
  parameter int PC_REG = 1
) (
  input logic          clk,
  input logic          reset_n,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [WIDTH-1:0] store [NREGS];
  logic [CNTW-1:0]  cnt   [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;
  logic             err_q;
  logic             w_pc;
  logic             iss_pc;

  function automatic logic is_pc(input logic [AW-1:0] a);
    return (PC_REG != 0) && (a == AW'(NREGS - 1));
  endfunction

  assign w_pc   = is_pc(bus.wa);
  assign iss_pc = is_pc(bus.iss_addr);

  // A full counter rejects the claim regardless of a same-cycle write.
  assign bus.iss_ready = iss_pc | (~bus.flush & (cnt[bus.iss_addr] != CMAX));
  assign bus.err       = err_q;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = bus.iss_valid & bus.iss_ready & ~iss_pc & (bus.iss_addr == AW'(r));
      dec[r] = bus.we & (bus.wa == AW'(r)) & (cnt[r] != '0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] a;
      logic          pc_hit;
      logic          byp;
      logic          dec_i;

      assign a      = bus.ra[gi*AW +: AW];
      assign pc_hit = is_pc(a);
      assign byp    = bus.we & (bus.wa == a);
      assign dec_i  = byp & (cnt[a] != '0);

      assign bus.rd[gi*WIDTH +: WIDTH] = pc_hit ? bus.pc_in :
                                         byp    ? bus.wd    : store[a];
      // The matching write in flight satisfies one pending claim via bypass.
      assign bus.rbusy[gi] = ~pc_hit & ((cnt[a] - CNTW'(dec_i)) != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) store[r] <= '0;
    end else if (bus.we && !w_pc) begin
      store[bus.wa] <= bus.wd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (bus.flush)
          cnt[r] <= '0;
        else if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNTW'(1);
        else if (dec[r] && !inc[r])
          cnt[r] <= cnt[r] - CNTW'(1);
      end
      // Writes during a flush belong to squashed claims and are not errors.
      if (bus.we && !w_pc && !bus.flush && (cnt[bus.wa] == '0))
        err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, PC read-through, hazard tracking,
// saturation back-pressure, flush, sticky error and asynchronous reset.
module tb_regfile_sb;
  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int NRD   = 2;
  localparam int AW    = 4;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_sb #(
    .WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .CNTW(2), .PC_REG(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we        = 1'b0;
    bus.iss_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  function automatic logic [31:0] rd0();
    return bus.rd[31:0];
  endfunction

  function automatic logic [31:0] rd1();
    return bus.rd[63:32];
  endfunction

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.ra = {a1, a0};
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    bus.ra       = '0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.iss_addr = '0;
    bus.pc_in    = 32'h108;
    idle();

    // Reset state
    step(); step();
    set_ra(4'd3, 4'd0);
    #1;
    chk("rst_rd0", rd0(), 32'h0);
    chk("rst_rd1", rd1(), 32'h0);
    chk("rst_rbusy", {30'd0, bus.rbusy}, 32'h0);
    chk("rst_iss_ready", {31'd0, bus.iss_ready}, 32'h1);
    chk("rst_err", {31'd0, bus.err}, 32'h0);

    // Release, plain read and PC read-through
    reset_n = 1'b1;
    step();
    set_ra(4'd3, 4'd15);
    #1;
    chk("read_r3", rd0(), 32'h0);
    chk("pc_read", rd1(), 32'h108);

    // Claim r5, then write it: bypass in the write cycle, storage afterwards
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd5;
    step();
    idle();
    bus.we = 1'b1; bus.wa = 4'd5; bus.wd = 32'hDEADBEEF;
    set_ra(4'd5, 4'd15);
    #1;
    chk("bypass_rd0", rd0(), 32'hDEADBEEF);
    chk("bypass_rbusy0", {31'd0, bus.rbusy[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("stored_rd0", rd0(), 32'hDEADBEEF);
    chk("stored_rbusy0", {31'd0, bus.rbusy[0]}, 32'h0);

    // Write to PC register is dropped and never flagged
    bus.we = 1'b1; bus.wa = 4'd15; bus.wd = 32'h55;
    #1;
    chk("pc_wr_same", rd1(), 32'h108);
    step();
    idle();
    #1;
    chk("pc_wr_after", rd1(), 32'h108);
    chk("pc_wr_err", {31'd0, bus.err}, 32'h0);

    // Hazard on r2
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd2;
    set_ra(4'd2, 4'd0);
    #1;
    chk("haz_iss_ready", {31'd0, bus.iss_ready}, 32'h1);
    step();
    idle();
    #1;
    chk("haz_rbusy", {31'd0, bus.rbusy[0]}, 32'h1);
    bus.we = 1'b1; bus.wa = 4'd2; bus.wd = 32'd7;
    #1;
    chk("haz_wr_rbusy", {31'd0, bus.rbusy[0]}, 32'h0);
    chk("haz_wr_rd0", rd0(), 32'd7);
    step();
    idle();
    #1;
    chk("haz_after_rbusy", {31'd0, bus.rbusy[0]}, 32'h0);
    chk("haz_after_rd0", rd0(), 32'd7);
    chk("haz_err", {31'd0, bus.err}, 32'h0);

    // Saturation on r4
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd4;
    set_ra(4'd4, 4'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sat_ready_%0d", k), {31'd0, bus.iss_ready}, 32'h1);
      step();
    end
    #1;
    chk("sat_full_ready", {31'd0, bus.iss_ready}, 32'h0);
    step();
    bus.iss_valid = 1'b0;
    bus.we = 1'b1; bus.wa = 4'd4; bus.wd = 32'h44;
    #1;
    chk("sat_ready_wr", {31'd0, bus.iss_ready}, 32'h0);
    chk("sat_rbusy_wr", {31'd0, bus.rbusy[0]}, 32'h1);
    step();
    idle();
    #1;
    chk("sat_ready_after", {31'd0, bus.iss_ready}, 32'h1);
    bus.we = 1'b1; bus.wa = 4'd4;
    step();
    idle();
    #1;
    chk("sat_rbusy_cnt1", {31'd0, bus.rbusy[0]}, 32'h1);

    // Simultaneous issue and write on r6 with cnt=1
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd6;
    set_ra(4'd6, 4'd7);
    step();
    bus.we = 1'b1; bus.wa = 4'd6; bus.wd = 32'h66;
    #1;
    chk("sim_rbusy_same", {31'd0, bus.rbusy[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("sim_rbusy_after", {31'd0, bus.rbusy[0]}, 32'h1);

    // Two claims on r7, then flush with a write to idle r10
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd7;
    step(); step();
    idle();
    #1;
    chk("fl_pre_rbusy1", {31'd0, bus.rbusy[1]}, 32'h1);
    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_addr = 4'd7;
    bus.we = 1'b1; bus.wa = 4'd10; bus.wd = 32'hA;
    #1;
    chk("fl_iss_ready", {31'd0, bus.iss_ready}, 32'h0);
    step();
    idle();
    #1;
    chk("fl_rbusy", {30'd0, bus.rbusy}, 32'h0);
    chk("fl_err", {31'd0, bus.err}, 32'h0);
    set_ra(4'd10, 4'd4);
    #1;
    chk("fl_wr_r10", rd0(), 32'hA);
    chk("fl_r4_clear", {31'd0, bus.rbusy[1]}, 32'h0);

    // Write to r9 with nothing pending sets sticky err
    bus.we = 1'b1; bus.wa = 4'd9; bus.wd = 32'h9;
    #1;
    chk("err_before", {31'd0, bus.err}, 32'h0);
    step();
    idle();
    #1;
    chk("err_set", {31'd0, bus.err}, 32'h1);
    step();
    #1;
    chk("err_sticky", {31'd0, bus.err}, 32'h1);

    // Asynchronous reset between edges
    bus.iss_valid = 1'b1; bus.iss_addr = 4'd3;
    step();
    idle();
    set_ra(4'd3, 4'd5);
    #1;
    chk("ar_pre_rbusy", {31'd0, bus.rbusy[0]}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("ar_rbusy", {31'd0, bus.rbusy[0]}, 32'h0);
    chk("ar_err", {31'd0, bus.err}, 32'h0);
    chk("ar_rd_r5", rd1(), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    #1;
    chk("ar_post_err", {31'd0, bus.err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
